// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory request/response bundle.
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemStall;
  logic        AccessErr;

  modport master (
    output MemRead, MemWrite, funct3, Addr, WriteData,
    input  ReadData, MemStall, AccessErr
  );

  modport slave (
    input  MemRead, MemWrite, funct3, Addr, WriteData,
    output ReadData, MemStall, AccessErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: RV32I byte/half/word loads and stores,
// stalls the pipeline for LATENCY cycles per access, flags bad accesses.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW      = ADDR_WIDTH + 2;
  localparam int unsigned Words   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            store_q, store_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            access_err_q, access_err_d;
  logic [31:0]     mem_q [Words];

  logic            req;
  logic [AW-1:0]   acc_addr;
  logic [2:0]      acc_f3;
  logic [31:0]     acc_wdata;
  logic            acc_store;
  logic            acc_err;
  logic            commit;
  logic            mem_we;
  logic [3:0]      be;
  logic [31:0]     wlane;
  logic [31:0]     word_rd;
  logic [31:0]     shifted;
  logic [31:0]     load_val;
  logic            unused_addr;

  assign req         = bus.MemRead | bus.MemWrite;
  assign unused_addr = ^bus.Addr[31:AW];

  // Operands of the committing access: live inputs in IDLE (single-cycle latency
  // commits straight from IDLE), captured copies otherwise.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = bus.Addr[AW-1:0];
      acc_f3    = bus.funct3;
      acc_wdata = bus.WriteData;
      acc_store = bus.MemWrite;
    end else begin
      acc_addr  = addr_q;
      acc_f3    = f3_q;
      acc_wdata = wdata_q;
      acc_store = store_q;
    end
  end

  // Commit strobe for the edge that enters DONE; reset kills a pending write.
  always_comb begin
    commit = 1'b0;
    unique case (state_q)
      StIdle:  commit = req && (LATENCY == 1);
      StBusy:  commit = (cnt_q == 4'd1);
      default: commit = 1'b0;
    endcase
    commit = commit & ~reset;
  end

  // Misalignment / illegal-funct3 detection.
  always_comb begin
    acc_err = 1'b0;
    case (acc_f3)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = acc_addr[0];
      3'b010:  acc_err = (acc_addr[1:0] != 2'b00);
      3'b100:  acc_err = acc_store;
      3'b101:  acc_err = acc_store | acc_addr[0];
      default: acc_err = 1'b1;
    endcase
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be    = 4'b0000;
    wlane = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << acc_addr[1:0];
        wlane = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{acc_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign mem_we = commit & acc_store & ~acc_err;

  // Load lane extraction and extension.
  always_comb begin
    word_rd  = mem_q[acc_addr[AW-1:2]];
    shifted  = word_rd >> {acc_addr[1:0], 3'b000};
    load_val = word_rd;
    case (acc_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = word_rd;
    endcase
  end

  // FSM next state, request capture and registered results.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    store_d      = store_q;
    read_data_d  = read_data_q;
    access_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = bus.Addr[AW-1:0];
          f3_d    = bus.funct3;
          wdata_d = bus.WriteData;
          store_d = bus.MemWrite;
          cnt_d   = CntInit;
          state_d = (LATENCY == 1) ? StDone : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      access_err_d = acc_err;
      if (!acc_store) read_data_d = acc_err ? 32'd0 : load_val;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      f3_q         <= 3'd0;
      wdata_q      <= 32'd0;
      store_q      <= 1'b0;
      read_data_q  <= 32'd0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      store_q      <= store_d;
      read_data_q  <= read_data_d;
      access_err_q <= access_err_d;
    end
  end

  // Byte-lane memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) mem_q[acc_addr[AW-1:2]][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

  assign bus.ReadData  = read_data_q;
  assign bus.AccessErr = access_err_q;
  assign bus.MemStall  = ~reset & (((state_q == StIdle) & req) | (state_q == StBusy));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responders at latencies 2, 4, 1 and 5 share one clock.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [4];
  logic        rd    [4];
  logic        wr    [4];
  logic [2:0]  f3    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdat  [4];
  logic [31:0] rdata [4];
  logic        stall [4];
  logic        aerr  [4];
  logic [31:0] hold_rd [4];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 5;
    dmem_responder_if bus ();
    assign bus.MemRead   = rd[g];
    assign bus.MemWrite  = wr[g];
    assign bus.funct3    = f3[g];
    assign bus.Addr      = addr[g];
    assign bus.WriteData = wdat[g];
    assign rdata[g]      = bus.ReadData;
    assign stall[g]      = bus.MemStall;
    assign aerr[g]       = bus.AccessErr;
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(Lat)) u_dut (
      .clk   (clk),
      .reset (rst[g]),
      .bus   (bus)
    );
  end

  function automatic int lat_of(int d);
    case (d)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 5;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered on a falling edge; returns on the falling edge after DONE.
  task automatic access(int d, bit r, bit w, logic [2:0] fn, logic [31:0] a, logic [31:0] wd,
                        bit exp_err, logic [31:0] exp_load, bit scramble, string tag);
    int n;
    int err_early;
    logic [31:0] exp_rd;
    rd[d] = r; wr[d] = w; f3[d] = fn; addr[d] = a; wdat[d] = wd;
    #1;
    n = 0;
    err_early = 0;
    while (stall[d] === 1'b1 && n < 40) begin
      n++;
      if (aerr[d] !== 1'b0) err_early++;
      @(negedge clk);
      if (scramble && n == 1) begin
        addr[d] = addr[d] ^ 32'h4;
        wdat[d] = ~wdat[d];
        f3[d]   = 3'b000;
      end
      #1;
    end
    check_eq({tag, " stall_cycles"}, 32'(n), 32'(lat_of(d)));
    check_eq({tag, " err_during_stall"}, 32'(err_early), 32'd0);
    check_eq({tag, " access_err"}, {31'd0, aerr[d]}, {31'd0, exp_err});
    if (r && !w) exp_rd = exp_err ? 32'd0 : exp_load;
    else         exp_rd = hold_rd[d];
    hold_rd[d] = exp_rd;
    check_eq({tag, " read_data"}, rdata[d], exp_rd);
    @(negedge clk);
  endtask

  task automatic idle(int d, int cycles);
    rd[d] = 1'b0; wr[d] = 1'b0;
    #1;
    check_eq("idle stall", {31'd0, stall[d]}, 32'd0);
    check_eq("idle err", {31'd0, aerr[d]}, 32'd0);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; f3[d] = 3'd0;
      addr[d] = 32'd0; wdat[d] = 32'd0; hold_rd[d] = 32'd0;
    end
    rd[0] = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check_eq("reset stall_with_req", {31'd0, stall[0]}, 32'd0);
    check_eq("reset read_data", rdata[0], 32'd0);
    check_eq("reset access_err", {31'd0, aerr[0]}, 32'd0);
    rd[0] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;

    // Latency 2: word round trip
    access(0, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0, "sw_100");
    access(0, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, "lw_100");
    idle(0, 1);
    // Sub-word
    access(0, 0, 1, 3'b010, 32'h200, 32'h0, 0, 32'h0, 0, "sw_200_clr");
    access(0, 0, 1, 3'b000, 32'h203, 32'h00000080, 0, 32'h0, 0, "sb_203");
    access(0, 1, 0, 3'b000, 32'h203, 32'h0, 0, 32'hFFFFFF80, 0, "lb_203");
    access(0, 1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h00000080, 0, "lbu_203");
    access(0, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h80000000, 0, "lw_200");
    access(0, 0, 1, 3'b001, 32'h202, 32'h00008001, 0, 32'h0, 0, "sh_202");
    access(0, 1, 0, 3'b001, 32'h202, 32'h0, 0, 32'hFFFF8001, 0, "lh_202");
    access(0, 1, 0, 3'b101, 32'h202, 32'h0, 0, 32'h00008001, 0, "lhu_202");
    access(0, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h80010000, 0, "lw_200b");
    // Misaligned and illegal
    access(0, 1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 0, "lw_101_err");
    access(0, 0, 1, 3'b001, 32'h101, 32'h00001234, 1, 32'h0, 0, "sh_101_err");
    access(0, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, "lw_100_after");
    access(0, 1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 0, "ld_f3_011_err");
    access(0, 0, 1, 3'b010, 32'h104, 32'h0BADF00D, 0, 32'h0, 0, "sw_104");
    access(0, 0, 1, 3'b100, 32'h104, 32'hFFFFFFFF, 1, 32'h0, 0, "st_f3_100_err");
    access(0, 1, 0, 3'b010, 32'h104, 32'h0, 0, 32'h0BADF00D, 0, "lw_104");
    access(0, 1, 0, 3'b001, 32'h203, 32'h0, 1, 32'h0, 0, "lh_203_err");
    access(0, 1, 0, 3'b101, 32'h201, 32'h0, 1, 32'h0, 0, "lhu_201_err");
    // Simultaneous read/write is a store; address wraps at 4 KiB
    access(0, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, "lw_100_again");
    access(0, 1, 1, 3'b010, 32'h1004, 32'h55AA55AA, 0, 32'h0, 0, "rw_1004");
    access(0, 1, 0, 3'b010, 32'h0004, 32'h0, 0, 32'h55AA55AA, 0, "lw_0004_wrap");
    idle(0, 1);

    // Latency 4: reset mid-store
    access(1, 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 32'h0, 0, "sw_40_old");
    idle(1, 1);
    rd[1] = 1'b0; wr[1] = 1'b1; f3[1] = 3'b010; addr[1] = 32'h40; wdat[1] = 32'h12345678;
    #1;
    check_eq("rst_mid stall_c1", {31'd0, stall[1]}, 32'd1);
    @(negedge clk); #1;
    check_eq("rst_mid stall_c2", {31'd0, stall[1]}, 32'd1);
    rst[1] = 1'b1;
    #1;
    check_eq("rst_mid stall_drop", {31'd0, stall[1]}, 32'd0);
    check_eq("rst_mid err", {31'd0, aerr[1]}, 32'd0);
    @(negedge clk); #1;
    check_eq("rst_mid stall_held", {31'd0, stall[1]}, 32'd0);
    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    access(1, 1, 0, 3'b010, 32'h40, 32'h0, 0, 32'hCAFEF00D, 0, "lw_40_kept");
    // Reset released with a load still requested starts a fresh access
    rd[1] = 1'b1; f3[1] = 3'b010; addr[1] = 32'h40;
    rst[1] = 1'b1;
    #1;
    check_eq("rst2 read_data", rdata[1], 32'd0);
    hold_rd[1] = 32'd0;
    @(negedge clk);
    rst[1] = 1'b0;
    access(1, 1, 0, 3'b010, 32'h40, 32'h0, 0, 32'hCAFEF00D, 0, "lw_40_fresh");
    idle(1, 1);

    // Latency 1: back-to-back, stall pattern 1,0,1,0,...
    access(2, 0, 1, 3'b010, 32'h0, 32'h11111111, 0, 32'h0, 0, "l1_sw_0");
    access(2, 0, 1, 3'b010, 32'h4, 32'h22222222, 0, 32'h0, 0, "l1_sw_4");
    access(2, 0, 1, 3'b010, 32'h8, 32'h33333333, 0, 32'h0, 0, "l1_sw_8");
    access(2, 1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h11111111, 0, "l1_lw_0");
    access(2, 1, 0, 3'b010, 32'h4, 32'h0, 0, 32'h22222222, 0, "l1_lw_4");
    access(2, 1, 0, 3'b010, 32'h8, 32'h0, 0, 32'h33333333, 0, "l1_lw_8");
    access(2, 1, 0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 0, "l1_lw_2_err");
    idle(2, 1);

    // Latency 5: inputs changed during BUSY are ignored
    access(3, 0, 1, 3'b010, 32'h14, 32'h0, 0, 32'h0, 0, "l5_sw_14_clr");
    access(3, 0, 1, 3'b010, 32'h10, 32'hA5A5A5A5, 0, 32'h0, 1, "l5_sw_10_scr");
    access(3, 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hA5A5A5A5, 0, "l5_lw_10");
    access(3, 1, 0, 3'b010, 32'h14, 32'h0, 0, 32'h0, 0, "l5_lw_14");
    access(3, 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hA5A5A5A5, 1, "l5_lw_10_scr");
    idle(3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V CPU. It answers the MEM stage's load/store requests with a fixed multi-cycle access latency. It holds the pipeline through `MemStall` until each access completes. It implements RV32I byte/half/word loads and stores with sign or zero extension, and flags misaligned or illegal accesses.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: memory holds 2^ADDR_WIDTH 32-bit words and is byte-addressed through `Addr[ADDR_WIDTH+1:0]`.
- `LATENCY`, default 2: number of stall cycles per access. Legal values are 1..15.

Ports:
- `clk`  in  1  the single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemRead`  in  1  load request from the MEM stage. Held by the pipeline while stalled.
- `MemWrite`  in  1  store request from the MEM stage. Held while stalled.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `Addr`  in  32  byte address.
- `WriteData`  in  32  store data. Bytes are taken from the low end.
- `ReadData`  out  32  extended load result.
- `MemStall`  out  1  pipeline hold request.
- `AccessErr`  out  1  one-cycle flag for a misaligned or illegal access.

## Operation
- `req = MemRead | MemWrite`. If both are high, the access is a store and `ReadData` is not updated.
- The FSM has three states: IDLE, BUSY, DONE.
  - IDLE: on `req`, capture `Addr`, `funct3`, `WriteData` and the op into registers and load `cnt = LATENCY-1`. Go to BUSY, or to DONE if `LATENCY == 1`. Without `req`, stay in IDLE.
  - BUSY: decrement `cnt` each cycle. When `cnt == 1` at the edge, go to DONE. Inputs are ignored in BUSY; only the captured copies are used.
  - DONE: go to IDLE unconditionally. `req` is ignored in DONE because the pipeline advances at the end of this cycle and the request still showing belongs to the finished access.
- `MemStall = (state==IDLE & req) | state==BUSY`. This is combinational so the request cycle itself stalls.
- Commit happens on the edge that enters DONE.
  - Store: byte-enables from `funct3` and `Addr[1:0]`. SB writes one lane, SH writes lanes {1:0} or {3:2}, SW writes all four.
  - Load: the addressed lane is extracted, then sign-extended (B/H) or zero-extended (BU/HU), and registered into `ReadData`.
- `ReadData` holds its value until the next load commits. Stores and errors do not change it, except that an erroring load writes 0.
- AccessErr conditions:
  - H/HU with `Addr[0]=1`.
  - W with `Addr[1:0]!=0`.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- On an error there is no memory write and a load returns `ReadData = 0`. The access still takes the full latency. `AccessErr` is high for exactly the DONE cycle.
- Address bits above `ADDR_WIDTH+1` are ignored, so addresses wrap modulo the memory size.
- Memory contents are not reset; simulation initializes them to 0.

## Timing
- Reset values: state IDLE, `cnt = 0`, `ReadData = 0`, `AccessErr = 0`. `MemStall = 0` while `reset` is high, regardless of `req`.
- Per access:
  - `MemStall` is high for exactly `LATENCY` consecutive cycles, starting with the cycle `req` is first seen in IDLE.
  - DONE follows with `MemStall = 0` and the result valid.
  - Total occupancy is `LATENCY+1` cycles.
- Back-to-back accesses: the request seen in the cycle after DONE starts a new access immediately. There is no dead cycle beyond DONE.
- A store followed by a load to the same address returns the new data, because the store committed before the load is captured.
- Reset asserted mid-access:
  - The FSM returns to IDLE immediately.
  - A pending store is dropped, with no partial write.
  - `MemStall` and `AccessErr` drop asynchronously.
  - After reset releases, a still-asserted `req` starts a fresh access.
- Changing `Addr`, `WriteData` or `funct3` during BUSY has no effect.

## Test plan
- Word round trip, `LATENCY = 2`: SW `0xDEADBEEF` to `0x100`, then LW `0x100`.
  - Expect `MemStall` high 2 cycles per access, with DONE cycles between.
  - Expect `ReadData = 0xDEADBEEF` in the load's DONE cycle.
- Sub-word access: SB `0x80` to `0x203`, then:
  - LB `0x203` gives `0xFFFFFF80`.
  - LBU `0x203` gives `0x00000080`.
  - LW `0x200` gives `0x80000000`.
  - SH `0x8001` to `0x202`, then LH `0x202` gives `0xFFFF8001` and LHU gives `0x00008001`.
- Misaligned and illegal access: LW at `0x101`.
  - Expect 2 stall cycles, `AccessErr = 1` in DONE only, and `ReadData = 0`.
  - SH at `0x101` leaves memory unchanged; a following LW `0x100` still returns the old word.
- Reset mid-access: SW `0x12345678` to `0x40` with `LATENCY = 4`, assert `reset` during the 2nd stall cycle.
  - Expect `MemStall` to drop at once.
  - A later LW `0x40` returns the pre-store value.
- Latency and back-to-back: `LATENCY = 1`, three consecutive LWs.
  - Expect the stall pattern 1,0,1,0,1,0.
  - Also check `LATENCY = 5`: exactly 5 stall cycles each, and inputs changed during BUSY are ignored.
- Simultaneous requests and wrap: `MemRead` and `MemWrite` both high with `ADDR_WIDTH = 10`.
  - The access is treated as a store and `ReadData` is unchanged.
  - SW to `0x1004` then LW `0x0004` returns the stored data (address wrap).
